// File: rtl/text_lcd_responder_if.sv
// LCD character-bus connection between a writer (master) and the responder (slave).
// Read results come back on rd_data/rd_valid.
interface text_lcd_responder_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;
  logic [7:0] rd_data;
  logic       rd_valid;

  modport master (
    output lcd_en, lcd_rs, lcd_rw, lcd_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  lcd_en, lcd_rs, lcd_rw, lcd_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/text_lcd_responder.sv
// HD44780-style 16x2 character controller: decodes bus cycles, holds DDRAM/AC/flags, models busy time.
// Executes 1 cycle after the synchronized en falling edge; writes arriving while busy are dropped (overrun).
module text_lcd_responder #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic                       clk,
  input  logic                       resetn,
  text_lcd_responder_if.slave        bus,
  input  logic [4:0]                 mon_addr,
  output logic [7:0]                 mon_char,
  output logic                       busy,
  output logic                       disp_on,
  output logic                       cursor_on,
  output logic                       blink_on,
  output logic                       func_ok,
  output logic                       overrun,
  output logic                       addr_err
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_BUSY} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [4:0]      fill_idx, fill_nxt;
  logic [6:0]      ac, ac_nxt;
  logic            id, id_nxt;
  logic            disp_nxt, cursor_nxt, blink_nxt, func_nxt;
  logic [7:0]      rd_data_q, rd_data_nxt;
  logic            rd_valid_nxt, overrun_nxt, addr_err_nxt;
  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [7:0]      wr_dat;
  logic [7:0]      ddram [32];

  logic            en_s1, en_s2, en_d;
  logic            en_fall, exec_q;
  logic            cap_rs, cap_rw;
  logic [7:0]      cap_dat;
  logic [4:0]      ac_idx;

  assign en_fall  = en_d & ~en_s2;
  assign ac_idx   = {ac[6], ac[3:0]};
  assign busy     = (state != ST_IDLE);
  assign bus.rd_data = rd_data_q;

  // Step AC through the two visible 16-char windows (0x00-0x0F, 0x40-0x4F).
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      case (a)
        7'h0F:   r = 7'h40;
        7'h4F:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h00:   r = 7'h4F;
        7'h40:   r = 7'h0F;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_d    <= 1'b0;
      exec_q  <= 1'b0;
      cap_rs  <= 1'b0;
      cap_rw  <= 1'b0;
      cap_dat <= 8'h00;
    end else begin
      en_s1  <= bus.lcd_en;
      en_s2  <= en_s1;
      en_d   <= en_s2;
      // A falling edge seen during the execute cycle is discarded.
      exec_q <= en_fall & ~exec_q;
      if (en_s2) begin
        cap_rs  <= bus.lcd_rs;
        cap_rw  <= bus.lcd_rw;
        cap_dat <= bus.lcd_data;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    fill_nxt     = fill_idx;
    ac_nxt       = ac;
    id_nxt       = id;
    disp_nxt     = disp_on;
    cursor_nxt   = cursor_on;
    blink_nxt    = blink_on;
    func_nxt     = func_ok;
    rd_data_nxt  = rd_data_q;
    rd_valid_nxt = 1'b0;
    overrun_nxt  = 1'b0;
    addr_err_nxt = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = ac_idx;
    wr_dat       = cap_dat;

    if (busy) cnt_nxt = cnt - CNT_ONE;

    case (state)
      ST_CLEAR: begin
        wr_en    = 1'b1;
        wr_idx   = fill_idx;
        wr_dat   = 8'h20;
        fill_nxt = fill_idx + 5'd1;
        if (fill_idx == 5'd31) begin
          ac_nxt    = 7'h00;
          id_nxt    = 1'b1;
          state_nxt = (cnt == CNT_ONE) ? ST_IDLE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_ONE) state_nxt = ST_IDLE;
      end
      default: ;
    endcase

    if (exec_q) begin
      if (cap_rw) begin
        rd_valid_nxt = 1'b1;
        if (!cap_rs) begin
          rd_data_nxt = {busy, ac};
        end else if (busy) begin
          rd_data_nxt = 8'hFF;
        end else begin
          rd_data_nxt = ddram[ac_idx];
          ac_nxt      = ac_step(ac, id);
        end
      end else if (busy) begin
        overrun_nxt = 1'b1;
      end else if (cap_rs) begin
        state_nxt = ST_BUSY;
        cnt_nxt   = BUSY_LD;
        wr_en     = 1'b1;
        wr_idx    = ac_idx;
        wr_dat    = cap_dat;
        ac_nxt    = ac_step(ac, id);
      end else begin
        state_nxt = ST_BUSY;
        cnt_nxt   = BUSY_LD;
        casez (cap_dat)
          8'b1???????: begin
            if (cap_dat[5:4] == 2'b00) ac_nxt = cap_dat[6:0];
            else                       addr_err_nxt = 1'b1;
          end
          8'b01??????: ;
          8'b001?????: begin
            if (cap_dat[4] && cap_dat[3]) func_nxt = 1'b1;
          end
          8'b0001????: begin
            if (!cap_dat[3]) ac_nxt = ac_step(ac, cap_dat[2]);
          end
          8'b00001???: begin
            disp_nxt   = cap_dat[2];
            cursor_nxt = cap_dat[1];
            blink_nxt  = cap_dat[0];
          end
          8'b000001??: id_nxt = cap_dat[1];
          8'b0000001?: ac_nxt = 7'h00;
          8'b00000001: begin
            state_nxt = ST_CLEAR;
            cnt_nxt   = CLEAR_LD;
            fill_nxt  = 5'd0;
          end
          default: begin
            // 0x00 is not a defined instruction: leave everything idle.
            state_nxt = state;
            cnt_nxt   = cnt;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      fill_idx     <= 5'd0;
      ac           <= 7'h00;
      id           <= 1'b1;
      disp_on      <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      func_ok      <= 1'b0;
      rd_data_q    <= 8'h00;
      bus.rd_valid <= 1'b0;
      overrun      <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      fill_idx     <= fill_nxt;
      ac           <= ac_nxt;
      id           <= id_nxt;
      disp_on      <= disp_nxt;
      cursor_on    <= cursor_nxt;
      blink_on     <= blink_nxt;
      func_ok      <= func_nxt;
      rd_data_q    <= rd_data_nxt;
      bus.rd_valid <= rd_valid_nxt;
      overrun      <= overrun_nxt;
      addr_err     <= addr_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      mon_char <= 8'h20;
    end else begin
      if (wr_en) ddram[wr_idx] <= wr_dat;
      mon_char <= ddram[mon_addr];
    end
  end

endmodule

// File: tb/tb_text_lcd_responder.sv
// Scoreboard bench for text_lcd_responder: reads push expected bytes, the rd_valid monitor pops them.
module tb_text_lcd_responder;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] mon_addr = 5'd0;
  logic [7:0] mon_char;
  logic       busy, disp_on, cursor_on, blink_on, func_ok, overrun, addr_err;

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0, aerr_cnt = 0, busy_cnt = 0;
  int base;
  logic [7:0] exp_q[$];
  logic [7:0] mdl [32];

  text_lcd_responder_if bus();

  text_lcd_responder dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .mon_addr(mon_addr), .mon_char(mon_char), .busy(busy),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .func_ok(func_ok), .overrun(overrun), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (overrun)  ovr_cnt++;
      if (addr_err) aerr_cnt++;
      if (busy)     busy_cnt++;
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else                   chk("rd_data", {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int post);
    @(posedge clk); #1;
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d; bus.lcd_en = 1'b1;
    repeat (6) @(posedge clk);
    #1 bus.lcd_en = 1'b0;
    repeat (post) @(posedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    xfer(1'b0, 1'b0, d, 6);
    repeat (50) @(posedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    xfer(1'b1, 1'b0, d, 6);
    repeat (50) @(posedge clk);
  endtask

  task automatic rd_stat(input logic [7:0] e);
    exp_q.push_back(e);
    xfer(1'b0, 1'b1, 8'h00, 6);
  endtask

  task automatic rd_dat(input logic [7:0] e);
    exp_q.push_back(e);
    xfer(1'b1, 1'b1, 8'h00, 6);
  endtask

  task automatic mon_rd(input logic [4:0] idx, output logic [7:0] v);
    @(negedge clk); mon_addr = idx;
    @(negedge clk); v = mon_char;
  endtask

  task automatic cmp_all(input string tag);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      mon_rd(5'(i), v);
      chk($sformatf("%s[%0d]", tag, i), {24'd0, v}, {24'd0, mdl[i]});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bit seen;
    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_func", func_ok, 0);
    chk("rst_disp", {disp_on, cursor_on, blink_on}, 3'b000);
    chk("rst_mon", mon_char, 8'h20);
    chk("rst_rdv", bus.rd_valid, 0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    // power-up sequence
    xfer(0, 0, 8'h38, 6); repeat (2001) @(posedge clk);
    xfer(0, 0, 8'h0E, 6); repeat (2001) @(posedge clk);
    xfer(0, 0, 8'h06, 6); repeat (2001) @(posedge clk);
    base = busy_cnt;
    xfer(0, 0, 8'h01, 6); repeat (2001) @(posedge clk);
    chk("clr_busy_len", busy_cnt - base, 1600);
    chk("func_ok", func_ok, 1);
    chk("disp_ctl", {disp_on, cursor_on, blink_on}, 3'b110);
    cmp_all("init");

    // second line start, data write, status
    base = busy_cnt;
    cmd(8'hC0);
    chk("wr_busy_len", busy_cnt - base, 40);
    wr(8'hFF); mdl[16] = 8'hFF;
    mon_rd(5'd16, v);
    chk("mon16", v, 8'hFF);
    rd_stat(8'h41);

    // line wrap forward and backward
    cmd(8'h8F);
    wr(8'h41); mdl[15] = 8'h41;
    wr(8'h42); mdl[16] = 8'h42;
    rd_stat(8'h41);
    cmd(8'h04);
    cmd(8'hC0);
    wr(8'h43); mdl[16] = 8'h43;
    rd_stat(8'h0F);
    rd_dat(8'h41);
    rd_stat(8'h0E);
    cmp_all("wrap");
    cmd(8'h06);

    // write dropped while clearing
    base = ovr_cnt;
    xfer(0, 0, 8'h01, 6);
    xfer(1, 0, 8'h58, 6);
    repeat (100) @(posedge clk);
    rd_stat(8'h80);
    rd_dat(8'hFF);
    repeat (1700) @(posedge clk);
    chk("overrun_cnt", ovr_cnt - base, 1);
    rd_stat(8'h00);
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    cmp_all("clr2");

    // address errors and cursor shifts
    cmd(8'hCF);
    rd_stat(8'h4F);
    base = aerr_cnt;
    cmd(8'h95);
    chk("addr_err_cnt", aerr_cnt - base, 1);
    rd_stat(8'h4F);
    cmd(8'h14);
    rd_stat(8'h00);
    cmd(8'h10);
    rd_stat(8'h4F);
    cmd(8'h18);
    rd_stat(8'h4F);
    cmd(8'h0D);
    chk("disp_ctl2", {disp_on, cursor_on, blink_on}, 3'b101);

    // reset in the middle of a clear
    cmd(8'hC4);
    wr(8'h51);
    mon_rd(5'd20, v);
    chk("mon20", v, 8'h51);
    xfer(0, 0, 8'h01, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("clr_started", seen, 1);
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_func", func_ok, 0);
    chk("mid_rst_disp", disp_on, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    cmp_all("midrst");
    rd_stat(8'h00);

    repeat (10) @(posedge clk);
    chk("rd_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
